// File: rtl/camera_pixel_assembler.sv
// Packs BYTES_PER_PIXEL camera bytes into one pixel word on PCLK rising edges detected in clk_in.
// Optional macro CAM_ASM_LINE_LEN_EN adds per-line pixel count and a line-length mismatch pulse.
module camera_pixel_assembler #(
   parameter int HCOUNT_WIDTH    = 11,
   parameter int VCOUNT_WIDTH    = 10,
   parameter int BYTES_PER_PIXEL = 2,
   parameter int MSB_FIRST       = 1,
   parameter int FRAME_CNT_WIDTH = 8
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic                         camera_pclk_in,
   input  logic                         camera_hs_in,
   input  logic                         camera_vs_in,
   input  logic [7:0]                   camera_data_in,
   output logic                         pixel_valid_out,
   output logic [HCOUNT_WIDTH-1:0]      pixel_hcount_out,
   output logic [VCOUNT_WIDTH-1:0]      pixel_vcount_out,
   output logic [8*BYTES_PER_PIXEL-1:0] pixel_data_out,
   output logic                         frame_start_out,
   output logic                         line_end_out,
   output logic [FRAME_CNT_WIDTH-1:0]   frame_count_out,
   output logic                         partial_err_out
`ifdef CAM_ASM_LINE_LEN_EN
   ,
   output logic [HCOUNT_WIDTH-1:0]      line_len_out,
   output logic                         line_len_err_out
`endif
);

   localparam int IDX_W = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_PIXEL - 1);

   typedef logic [BYTES_PER_PIXEL-1:0][7:0] pixel_t;

   logic                       pclkPrev_q, pclkPrev_d;
   logic                       lastHs_q, lastHs_d;
   logic                       lastVs_q, lastVs_d;
   logic                       inFrame_q, inFrame_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic [HCOUNT_WIDTH-1:0]    hcount_q, hcount_d;
   logic [VCOUNT_WIDTH-1:0]    vcount_q, vcount_d;
   pixel_t                     pixBuf_q, pixBuf_d;
   logic                       valid_q, valid_d;
   logic [HCOUNT_WIDTH-1:0]    hcountOut_q, hcountOut_d;
   logic [VCOUNT_WIDTH-1:0]    vcountOut_q, vcountOut_d;
   pixel_t                     data_q, data_d;
   logic                       frameStart_q, frameStart_d;
   logic                       lineEnd_q, lineEnd_d;
   logic [FRAME_CNT_WIDTH-1:0] frameCnt_q, frameCnt_d;
   logic                       partialErr_q, partialErr_d;
`ifdef CAM_ASM_LINE_LEN_EN
   logic [HCOUNT_WIDTH-1:0]    lineLen_q, lineLen_d;
   logic                       lineLenErr_q, lineLenErr_d;
   logic [HCOUNT_WIDTH-1:0]    lineRef_q, lineRef_d;
   logic                       refValid_q, refValid_d;
`endif

   logic                       sample;
   logic                       hsFall;
   logic [IDX_W-1:0]           slot;
   pixel_t                     merged;

   // VS low takes priority over line end, which takes priority over byte capture.
   always_comb begin
      sample       = !pclkPrev_q && camera_pclk_in;
      hsFall       = lastHs_q && !camera_hs_in && camera_vs_in;
      slot         = (MSB_FIRST != 0) ? (LAST_IDX - idx_q) : idx_q;
      merged       = pixBuf_q;
      merged[slot] = camera_data_in;

      pclkPrev_d   = camera_pclk_in;
      lastHs_d     = lastHs_q;
      lastVs_d     = lastVs_q;
      inFrame_d    = inFrame_q;
      idx_d        = idx_q;
      hcount_d     = hcount_q;
      vcount_d     = vcount_q;
      pixBuf_d     = pixBuf_q;
      valid_d      = 1'b0;
      hcountOut_d  = hcountOut_q;
      vcountOut_d  = vcountOut_q;
      data_d       = data_q;
      frameStart_d = 1'b0;
      lineEnd_d    = 1'b0;
      frameCnt_d   = frameCnt_q;
      partialErr_d = 1'b0;
`ifdef CAM_ASM_LINE_LEN_EN
      lineLen_d    = lineLen_q;
      lineLenErr_d = 1'b0;
      lineRef_d    = lineRef_q;
      refValid_d   = refValid_q;
`endif

      if (sample) begin
         lastHs_d = camera_hs_in;
         lastVs_d = camera_vs_in;
         if (!camera_vs_in) begin
            vcount_d    = '0;
            hcount_d    = '0;
            idx_d       = '0;
            hcountOut_d = '0;
            vcountOut_d = '0;
`ifdef CAM_ASM_LINE_LEN_EN
            refValid_d  = 1'b0;
`endif
            if (lastVs_q) begin
               frameCnt_d = frameCnt_q + 1'b1;
               inFrame_d  = 1'b0;
            end
         end else if (hsFall) begin
            lineEnd_d    = 1'b1;
            vcount_d     = vcount_q + 1'b1;
            vcountOut_d  = vcount_q + 1'b1;
            hcount_d     = '0;
            partialErr_d = (idx_q != '0);
            idx_d        = '0;
`ifdef CAM_ASM_LINE_LEN_EN
            lineLen_d    = hcount_q;
            lineLenErr_d = refValid_q && (hcount_q != lineRef_q);
            lineRef_d    = hcount_q;
            refValid_d   = 1'b1;
`endif
         end else if (!camera_hs_in) begin
            idx_d = '0;
         end else begin
            pixBuf_d = merged;
            if (idx_q == LAST_IDX) begin
               valid_d      = 1'b1;
               data_d       = merged;
               hcountOut_d  = hcount_q;
               vcountOut_d  = vcount_q;
               hcount_d     = hcount_q + 1'b1;
               idx_d        = '0;
               frameStart_d = !inFrame_q;
               inFrame_d    = 1'b1;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         pclkPrev_q   <= 1'b0;
         lastHs_q     <= 1'b0;
         lastVs_q     <= 1'b0;
         inFrame_q    <= 1'b0;
         idx_q        <= '0;
         hcount_q     <= '0;
         vcount_q     <= '0;
         pixBuf_q     <= '0;
         valid_q      <= 1'b0;
         hcountOut_q  <= '0;
         vcountOut_q  <= '0;
         data_q       <= '0;
         frameStart_q <= 1'b0;
         lineEnd_q    <= 1'b0;
         frameCnt_q   <= '0;
         partialErr_q <= 1'b0;
`ifdef CAM_ASM_LINE_LEN_EN
         lineLen_q    <= '0;
         lineLenErr_q <= 1'b0;
         lineRef_q    <= '0;
         refValid_q   <= 1'b0;
`endif
      end else begin
         pclkPrev_q   <= pclkPrev_d;
         lastHs_q     <= lastHs_d;
         lastVs_q     <= lastVs_d;
         inFrame_q    <= inFrame_d;
         idx_q        <= idx_d;
         hcount_q     <= hcount_d;
         vcount_q     <= vcount_d;
         pixBuf_q     <= pixBuf_d;
         valid_q      <= valid_d;
         hcountOut_q  <= hcountOut_d;
         vcountOut_q  <= vcountOut_d;
         data_q       <= data_d;
         frameStart_q <= frameStart_d;
         lineEnd_q    <= lineEnd_d;
         frameCnt_q   <= frameCnt_d;
         partialErr_q <= partialErr_d;
`ifdef CAM_ASM_LINE_LEN_EN
         lineLen_q    <= lineLen_d;
         lineLenErr_q <= lineLenErr_d;
         lineRef_q    <= lineRef_d;
         refValid_q   <= refValid_d;
`endif
      end
   end

   assign pixel_valid_out  = valid_q;
   assign pixel_hcount_out = hcountOut_q;
   assign pixel_vcount_out = vcountOut_q;
   assign pixel_data_out   = data_q;
   assign frame_start_out  = frameStart_q;
   assign line_end_out     = lineEnd_q;
   assign frame_count_out  = frameCnt_q;
   assign partial_err_out  = partialErr_q;
`ifdef CAM_ASM_LINE_LEN_EN
   assign line_len_out     = lineLen_q;
   assign line_len_err_out = lineLenErr_q;
`endif

endmodule

// File: tb/tb_camera_pixel_assembler.sv
// Table-driven bench for camera_pixel_assembler: vectors push expected events to a scoreboard,
// a negedge monitor pops them when the DUT pulses; a second instance covers BPP=3, LSB-first packing.
module tb_camera_pixel_assembler;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pclk = 1'b0, hs = 1'b0, vs = 1'b0;
   logic [7:0]  camData = 8'h00;
   logic        pixValid, frameStart, lineEnd, partialErr;
   logic [10:0] pixHcount;
   logic [9:0]  pixVcount;
   logic [15:0] pixData;
   logic [7:0]  frameCount;
`ifdef CAM_ASM_LINE_LEN_EN
   logic [10:0] lineLen;
   logic        lineLenErr;
`endif

   logic        pclk3 = 1'b0, hs3 = 1'b0, vs3 = 1'b0;
   logic [7:0]  camData3 = 8'h00;
   logic        pixValid3, frameStart3, lineEnd3, partialErr3;
   logic [10:0] pixHcount3;
   logic [9:0]  pixVcount3;
   logic [23:0] pixData3;
   logic [7:0]  frameCount3;
`ifdef CAM_ASM_LINE_LEN_EN
   logic [10:0] lineLen3;
   logic        lineLenErr3;
`endif

   int vectors = 0;
   int miscompares = 0;
   int cycleCnt = 0;

   typedef struct {
      logic        hs;
      logic        vs;
      logic [7:0]  data;
      logic        ev;
      logic        pv;
      logic [15:0] pd;
      int          hc;
      int          vc;
      logic        fs;
      logic        le;
      logic        pe;
      int          fc;
      int          ll;
      logic        lle;
   } vec_t;

   typedef struct {
      vec_t v;
      int   cyc;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   camera_pixel_assembler #(
      .HCOUNT_WIDTH(11), .VCOUNT_WIDTH(10), .BYTES_PER_PIXEL(2), .MSB_FIRST(1), .FRAME_CNT_WIDTH(8)
   ) dut (
      .clk_in(clk), .rst_in(rst), .camera_pclk_in(pclk), .camera_hs_in(hs), .camera_vs_in(vs),
      .camera_data_in(camData), .pixel_valid_out(pixValid), .pixel_hcount_out(pixHcount),
      .pixel_vcount_out(pixVcount), .pixel_data_out(pixData), .frame_start_out(frameStart),
      .line_end_out(lineEnd), .frame_count_out(frameCount), .partial_err_out(partialErr)
`ifdef CAM_ASM_LINE_LEN_EN
      , .line_len_out(lineLen), .line_len_err_out(lineLenErr)
`endif
   );

   camera_pixel_assembler #(
      .HCOUNT_WIDTH(11), .VCOUNT_WIDTH(10), .BYTES_PER_PIXEL(3), .MSB_FIRST(0), .FRAME_CNT_WIDTH(8)
   ) dut3 (
      .clk_in(clk), .rst_in(rst), .camera_pclk_in(pclk3), .camera_hs_in(hs3), .camera_vs_in(vs3),
      .camera_data_in(camData3), .pixel_valid_out(pixValid3), .pixel_hcount_out(pixHcount3),
      .pixel_vcount_out(pixVcount3), .pixel_data_out(pixData3), .frame_start_out(frameStart3),
      .line_end_out(lineEnd3), .frame_count_out(frameCount3), .partial_err_out(partialErr3)
`ifdef CAM_ASM_LINE_LEN_EN
      , .line_len_out(lineLen3), .line_len_err_out(lineLenErr3)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycleCnt);
      end
   endtask

   task automatic addVec(input logic h, input logic v, input logic [7:0] d, input logic ev,
                         input logic pv, input logic [15:0] pd, input int hc, input int vc,
                         input logic fs, input logic le, input logic pe, input int fc,
                         input int ll, input logic lle);
      vec_t t;
      t.hs = h; t.vs = v; t.data = d; t.ev = ev; t.pv = pv; t.pd = pd; t.hc = hc; t.vc = vc;
      t.fs = fs; t.le = le; t.pe = pe; t.fc = fc; t.ll = ll; t.lle = lle;
      vecs.push_back(t);
   endtask

   task automatic gap(input logic h, input logic v);
      addVec(h, v, 8'h00, 1'b0, 1'b0, 16'h0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
   endtask

   task automatic byteNo(input logic [7:0] d);
      addVec(1'b1, 1'b1, d, 1'b0, 1'b0, 16'h0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
   endtask

   task automatic pix(input logic [7:0] d, input logic [15:0] pd, input int hc, input int vc,
                      input logic fs, input int fc);
      addVec(1'b1, 1'b1, d, 1'b1, 1'b1, pd, hc, vc, fs, 1'b0, 1'b0, fc, 0, 1'b0);
   endtask

   task automatic lend(input int vc, input logic pe, input int fc, input int ll, input logic lle);
      addVec(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 16'h0, 0, vc, 1'b0, 1'b1, pe, fc, ll, lle);
   endtask

   // One PCLK period spanning two clk cycles; the S edge falls on the second posedge.
   task automatic applyStimulus(input vec_t v);
      exp_t e;
      hs = v.hs; vs = v.vs; camData = v.data; pclk = 1'b0;
      @(negedge clk);
      pclk = 1'b1;
      if (v.ev) begin
         e.v = v;
         e.cyc = cycleCnt + 1;
         sb.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_valid"}, pixValid, 0);
      checkOutput({tag, "_hcount"}, pixHcount, 0);
      checkOutput({tag, "_vcount"}, pixVcount, 0);
      checkOutput({tag, "_data"}, pixData, 0);
      checkOutput({tag, "_frameStart"}, frameStart, 0);
      checkOutput({tag, "_lineEnd"}, lineEnd, 0);
      checkOutput({tag, "_frameCount"}, frameCount, 0);
      checkOutput({tag, "_partialErr"}, partialErr, 0);
`ifdef CAM_ASM_LINE_LEN_EN
      checkOutput({tag, "_lineLen"}, lineLen, 0);
      checkOutput({tag, "_lineLenErr"}, lineLenErr, 0);
`endif
   endtask

   task automatic sendByte3(input logic [7:0] d);
      hs3 = 1'b1; vs3 = 1'b1; camData3 = d; pclk3 = 1'b0;
      @(negedge clk);
      pclk3 = 1'b1;
      @(negedge clk);
   endtask

   // Scoreboard monitor: every pulse on the main instance must match the oldest queued event.
   always @(negedge clk) begin
      logic [4:0] pulses;
      exp_t e;
      pulses = {pixValid, frameStart, lineEnd, partialErr, 1'b0};
`ifdef CAM_ASM_LINE_LEN_EN
      pulses[0] = lineLenErr;
`endif
      if (rst && (pulses != 5'b0)) begin
         if (sb.size() == 0) begin
            checkOutput("unexpectedPulse", {27'b0, pulses}, 0);
         end else begin
            e = sb.pop_front();
            checkOutput("eventCycle", cycleCnt, e.cyc);
            checkOutput("pixelValid", pixValid, e.v.pv);
            checkOutput("frameStart", frameStart, e.v.fs);
            checkOutput("lineEnd", lineEnd, e.v.le);
            checkOutput("partialErr", partialErr, e.v.pe);
            checkOutput("vcount", pixVcount, e.v.vc);
            checkOutput("frameCount", frameCount, e.v.fc);
            if (e.v.pv) begin
               checkOutput("pixelData", pixData, e.v.pd);
               checkOutput("hcount", pixHcount, e.v.hc);
            end
`ifdef CAM_ASM_LINE_LEN_EN
            checkOutput("lineLenErr", lineLenErr, e.v.lle);
            if (e.v.le) checkOutput("lineLen", lineLen, e.v.ll);
`endif
         end
      end
   end

   initial begin
      #1ms;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t v;

      // Frame A: line 0 four pixels, line 1 four pixels, line 2 three pixels plus a stray byte.
      gap(1'b0, 1'b0);
      byteNo(8'hAB); pix(8'hCD, 16'hABCD, 0, 0, 1'b1, 0);
      byteNo(8'h12); pix(8'h34, 16'h1234, 1, 0, 1'b0, 0);
      byteNo(8'h56); pix(8'h78, 16'h5678, 2, 0, 1'b0, 0);
      byteNo(8'h9A); pix(8'hBC, 16'h9ABC, 3, 0, 1'b0, 0);
      lend(1, 1'b0, 0, 4, 1'b0);
      gap(1'b0, 1'b1);
      byteNo(8'h01); pix(8'h02, 16'h0102, 0, 1, 1'b0, 0);
      byteNo(8'h03); pix(8'h04, 16'h0304, 1, 1, 1'b0, 0);
      byteNo(8'h05); pix(8'h06, 16'h0506, 2, 1, 1'b0, 0);
      byteNo(8'h07); pix(8'h08, 16'h0708, 3, 1, 1'b0, 0);
      lend(2, 1'b0, 0, 4, 1'b0);
      gap(1'b0, 1'b1);
      byteNo(8'hE1); pix(8'hE2, 16'hE1E2, 0, 2, 1'b0, 0);
      byteNo(8'hE3); pix(8'hE4, 16'hE3E4, 1, 2, 1'b0, 0);
      byteNo(8'hE5); pix(8'hE6, 16'hE5E6, 2, 2, 1'b0, 0);
      byteNo(8'hE7);
      lend(3, 1'b1, 0, 3, 1'b1);
      gap(1'b0, 1'b0);
      // Frame B: one pixel, then HS and VS fall together with a byte pending.
      byteNo(8'hF0); pix(8'hF1, 16'hF0F1, 0, 0, 1'b1, 1);
      byteNo(8'hF2);
      gap(1'b0, 1'b0);
      // Frame C: the dropped F2 must not leak into this pixel.
      byteNo(8'hAA); pix(8'hBB, 16'hAABB, 0, 0, 1'b1, 2);
      lend(1, 1'b0, 2, 1, 1'b0);
      gap(1'b0, 1'b0);

      rst = 1'b0;
      repeat (3) @(negedge clk);
      checkIdle("reset");
      rst = 1'b1;

      foreach (vecs[i]) applyStimulus(vecs[i]);

      checkOutput("frameCountAfterVs", frameCount, 3);
      checkOutput("vcountAfterVs", pixVcount, 0);
      checkOutput("hcountAfterVs", pixHcount, 0);

      // Reset with one byte already captured: the stale byte must be discarded.
      v = vecs[1];
      applyStimulus(v);
      rst = 1'b0; pclk = 1'b0;
      @(negedge clk);
      checkIdle("midReset");
      rst = 1'b1;
      vecs.delete();
      byteNo(8'h11); pix(8'h22, 16'h1122, 0, 0, 1'b1, 0);
      foreach (vecs[i]) applyStimulus(vecs[i]);

      // Three-byte LSB-first pixel on the second instance.
      sendByte3(8'h11);
      checkOutput("bpp3_byte0_valid", pixValid3, 0);
      sendByte3(8'h22);
      checkOutput("bpp3_byte1_valid", pixValid3, 0);
      sendByte3(8'h33);
      checkOutput("bpp3_valid", pixValid3, 1);
      checkOutput("bpp3_data", pixData3, 24'h332211);
      checkOutput("bpp3_frameStart", frameStart3, 1);
      checkOutput("bpp3_hcount", pixHcount3, 0);
      pclk3 = 1'b0;
      @(negedge clk);
      checkOutput("bpp3_validWidth", pixValid3, 0);
      checkOutput("bpp3_frameStartWidth", frameStart3, 0);

      repeat (4) @(negedge clk);
      checkOutput("pendingEvents", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/camera_pixel_assembler.md
Name: camera_pixel_assembler

Overview:
Parametrised successor to the camera byte-to-pixel path. It samples a parallel camera bus on PCLK rising edges detected in the system clock domain and packs BYTES_PER_PIXEL consecutive bytes into one pixel word. It outputs pixel position, frame/line markers, a frame counter and a framing-error flag. It sits between the camera input pins (already synchronised) and the frame-buffer writer.

Parameters:
HCOUNT_WIDTH, 11, width of pixel column counter
VCOUNT_WIDTH, 10, width of line counter
BYTES_PER_PIXEL, 2, bytes packed per pixel; legal 1..4
MSB_FIRST, 1, 1: first byte lands in the most significant byte; 0: first byte lands in the least significant byte
FRAME_CNT_WIDTH, 8, width of frame counter

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous reset, active-low (0 = reset)
camera_pclk_in  input  1  camera pixel clock, sampled as data
camera_hs_in  input  1  line valid, high during active bytes
camera_vs_in  input  1  frame valid, high during frame
camera_data_in  input  8  camera byte
pixel_valid_out  output  1  one-cycle pulse: pixel word valid
pixel_hcount_out  output  HCOUNT_WIDTH  column of emitted pixel
pixel_vcount_out  output  VCOUNT_WIDTH  line of emitted pixel
pixel_data_out  output  8*BYTES_PER_PIXEL  packed pixel
frame_start_out  output  1  pulse on first pixel of a frame
line_end_out  output  1  pulse on HS falling edge while VS high
frame_count_out  output  FRAME_CNT_WIDTH  completed frames, wraps
partial_err_out  output  1  pulse: HS fell with a partially packed pixel

Behaviour:
- Sample event S: pclk_prev==0 && camera_pclk_in==1 in cycle t. All actions below occur on S. Outputs are registered and visible in cycle t+1. All pulses are exactly one cycle wide.
- Reset (rst_in==0 at a clk_in edge): all outputs 0, byte index 0, hcount 0, pclk_prev 0, last_hs 0, last_vs 0, in_frame 0. Reset mid-pixel discards the partial bytes.
- Byte packing:
  - On S with hs&&vs: store the byte at index idx. If MSB_FIRST, byte k goes to bits [8*(BPP-1-k) +: 8]; otherwise to [8*k +: 8].
  - idx increments. When idx==BPP-1, emit the pixel:
    - pixel_valid_out=1.
    - pixel_data_out = packed word including the current byte.
    - pixel_hcount_out = hcount, then hcount+=1 (wraps at 2^HCOUNT_WIDTH).
    - idx=0.
  - BPP=1: every qualifying S emits a pixel.
- Line end: on S with last_hs==1 && hs==0 && vs==1:
  - line_end_out=1.
  - vcount+=1 (wraps), hcount=0.
  - If idx!=0: partial_err_out=1 and idx=0; the partial bytes are dropped and no pixel is emitted.
- S with !hs and no line end: idx=0, no error.
- Frame boundary:
  - On S with vs==0: vcount=0, hcount=0, idx=0.
  - If last_vs==1 (VS falling): frame_count_out+=1 (wraps) and in_frame=0.
  - VS low also forces pixel_hcount_out and pixel_vcount_out to 0.
- frame_start_out: asserted together with the first pixel_valid_out after VS rises (in_frame==0). That emission sets in_frame=1.
- Simultaneous events:
  - HS falls while VS falls on the same S: VS handling wins; no line_end_out, no partial_err_out, frame_count increments.
  - A pixel emitted on the last byte before HS falls carries the old vcount.
- pixel_vcount_out reflects the current line counter and updates on the line-end event.
- No flow control downstream: the consumer must accept every pulse.

Optional Feature:
Macro CAM_ASM_LINE_LEN_EN.
- Defined: adds output line_len_out [HCOUNT_WIDTH] and pulse line_len_err_out. On each line end, line_len_out is loaded with the pixel count of the completed line. If this differs from the previous line's count within the same frame, line_len_err_out=1 for one cycle. The first line of each frame sets the reference value and never flags.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- BPP=2, MSB_FIRST=1, VS=1, HS=1, bytes 0xAB,0xCD,0x12,0x34 -> two pulses: data 0xABCD at hcount 0, then 0x1234 at hcount 1, each one cycle after its second-byte S.
- BPP=3, MSB_FIRST=0, bytes 0x11,0x22,0x33 -> pixel_data_out=0x332211, frame_start_out=1 with this first pixel of the frame.
- BPP=2, HS falls after 3 bytes -> one pixel, then line_end_out=1 and partial_err_out=1; vcount 0->1, hcount back to 0.
- Two lines of 4 pixels, then VS low -> vcount resets to 0, frame_count_out 0->1. The next frame's first pixel has vcount 0 and frame_start_out=1.
- Assert rst_in=0 mid-pixel (after 1 byte) for one cycle, then resume -> all outputs 0. The next complete byte pair forms a pixel at hcount 0 (no stale byte).
- CAM_ASM_LINE_LEN_EN defined: lines of 4, 4, 3 pixels -> line_len_out 4, 4, 3; line_len_err_out pulses only on the third line end.
